// File: rtl/adder_sequencer_pkg.sv
// Shared constants, FSM encoding and index sizing for the multi-word adder sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_sequencer_pkg;

    // Width of the external look-ahead adder; every slice matches it.
    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to address every slice; at least one bit so the counter is never zero-width.
    function automatic int index_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/multi_word_adder_sequencer_if.sv
// Request/result handshake plus the slice bus toward the external 16-bit adder.
// Latency: wires only.
// Backpressure: Ready_Out gates Start_In; the slice bus has no flow control.
interface multi_word_adder_sequencer_if #(
    parameter int NUM_WORDS = 4
);
    localparam int OPERAND_WIDTH = adder_sequencer_pkg::WORD_WIDTH * NUM_WORDS;
    localparam int WW            = adder_sequencer_pkg::WORD_WIDTH;

    logic                     Start_In;
    logic                     Ready_Out;
    logic [OPERAND_WIDTH-1:0] Data_A_In;
    logic [OPERAND_WIDTH-1:0] Data_B_In;
    logic                     Carry_In;
    logic                     Slice_Enable_Out;
    logic [WW-1:0]            Slice_A_Out;
    logic [WW-1:0]            Slice_B_Out;
    logic                     Slice_Carry_Out;
    logic [WW-1:0]            Slice_Sum_In;
    logic                     Slice_Carry_In;
    logic [OPERAND_WIDTH-1:0] Sum_Out;
    logic                     Carry_Out;
    logic                     Overflow_Out;
    logic                     Done_Out;

    // Sequencer side.
    modport slave (
        input  Start_In, Data_A_In, Data_B_In, Carry_In, Slice_Sum_In, Slice_Carry_In,
        output Ready_Out, Slice_Enable_Out, Slice_A_Out, Slice_B_Out, Slice_Carry_Out,
               Sum_Out, Carry_Out, Overflow_Out, Done_Out
    );

    // Requester plus adder side.
    modport master (
        output Start_In, Data_A_In, Data_B_In, Carry_In, Slice_Sum_In, Slice_Carry_In,
        input  Ready_Out, Slice_Enable_Out, Slice_A_Out, Slice_B_Out, Slice_Carry_Out,
               Sum_Out, Carry_Out, Overflow_Out, Done_Out
    );

endinterface

// File: rtl/word_slice_mux.sv
// Selects one WORD_WIDTH slice of a full-width operand by slice index.
// Latency: combinational.
// Backpressure: none.
module word_slice_mux
    import adder_sequencer_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [WORD_WIDTH*NUM_WORDS-1:0] operand,
    input  logic [IDX_W-1:0]                index,
    output logic [WORD_WIDTH-1:0]           slice
);

    // Compare against every constant slice position; out-of-range index yields zero.
    always_comb begin
        slice = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (index == IDX_W'(w)) begin
                slice = operand[w*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/multi_word_adder_sequencer.sv
// Adds two NUM_WORDS-slice operands one slice per cycle through an external 16-bit adder.
// Latency: Done_Out NUM_WORDS+1 cycles after the accepting edge; one op per NUM_WORDS+2 cycles.
// Backpressure: Ready_Out high only in IDLE; Start_In outside IDLE is dropped, not queued.
module multi_word_adder_sequencer
    import adder_sequencer_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                        Clock_In,
    input  logic                        Reset_In,
    multi_word_adder_sequencer_if.slave bus
);

    localparam int              OPERAND_WIDTH = WORD_WIDTH * NUM_WORDS;
    localparam int              IDX_W         = index_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_WORDS - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [OPERAND_WIDTH-1:0] op_a;
    logic [OPERAND_WIDTH-1:0] op_b;
    logic [OPERAND_WIDTH-1:0] sum_r;
    logic                     carry_w;
    logic                     carry_out_r;
    logic                     ovf_r;
    logic                     accept;
    logic                     step;
    logic                     last_step;
    logic [WORD_WIDTH-1:0]    slice_a;
    logic [WORD_WIDTH-1:0]    slice_b;
    logic                     in_run;

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.Start_In) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last_step = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, slice counter, carry chain and result capture.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            idx         <= '0;
            carry_w     <= 1'b0;
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept) begin
            op_a        <= bus.Data_A_In;
            op_b        <= bus.Data_B_In;
            carry_w     <= bus.Carry_In;
            idx         <= '0;
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (step) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (idx == IDX_W'(w)) begin
                    sum_r[w*WORD_WIDTH +: WORD_WIDTH] <= bus.Slice_Sum_In;
                end
            end
            carry_w <= bus.Slice_Carry_In;
            if (last_step) begin
                // Index parks on the top slice; the next accept rewinds it.
                carry_out_r <= bus.Slice_Carry_In;
                ovf_r       <= (op_a[OPERAND_WIDTH-1] == op_b[OPERAND_WIDTH-1]) &&
                               (bus.Slice_Sum_In[WORD_WIDTH-1] != op_a[OPERAND_WIDTH-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    word_slice_mux #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mux_a (
        .operand (op_a),
        .index   (idx),
        .slice   (slice_a)
    );

    word_slice_mux #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mux_b (
        .operand (op_b),
        .index   (idx),
        .slice   (slice_b)
    );

    // The adder only sees live operands while enabled; elsewhere the slice bus rests at zero.
    assign in_run               = (state == ST_RUN);
    assign bus.Ready_Out        = (state == ST_IDLE);
    assign bus.Slice_Enable_Out = in_run;
    assign bus.Slice_A_Out      = in_run ? slice_a : '0;
    assign bus.Slice_B_Out      = in_run ? slice_b : '0;
    assign bus.Slice_Carry_Out  = in_run & carry_w;
    assign bus.Sum_Out          = sum_r;
    assign bus.Carry_Out        = carry_out_r;
    assign bus.Overflow_Out     = ovf_r;
    assign bus.Done_Out         = (state == ST_DONE);

endmodule

// File: tb/tb_multi_word_adder_sequencer.sv
// Self-checking bench: table of full-width adds plus hand sequences for ignore/reset/streaming.
// Latency: expects Done_Out four cycles after the accepting edge's following cycle (label 5).
// Backpressure: drives Start_In only when the bench knows the sequencer is idle, except in the ignore test.
module tb_multi_word_adder_sequencer;

    localparam int NW = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];
    vec_t vecs[7];

    multi_word_adder_sequencer_if #(.NUM_WORDS(NW)) bus ();

    multi_word_adder_sequencer #(.NUM_WORDS(NW)) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    // External 16-bit adder; drives junk while disabled so stray captures show up.
    logic [16:0] add_full;
    assign add_full           = {1'b0, bus.Slice_A_Out} + {1'b0, bus.Slice_B_Out} + {16'b0, bus.Slice_Carry_Out};
    assign bus.Slice_Sum_In   = bus.Slice_Enable_Out ? add_full[15:0] : 16'hDEAD;
    assign bus.Slice_Carry_In = bus.Slice_Enable_Out ? add_full[16] : 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every Done_Out must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.Done_Out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("sum", bus.Sum_Out, e.sum);
                chk("carry", 64'(bus.Carry_Out), 64'(e.cout));
                chk("overflow", 64'(bus.Overflow_Out), 64'(e.ovf));
            end
        end
    end

    // One op from idle: checks RUN-window enables, cleared flags, held result afterwards.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic [63:0] esum, input logic ecout, input logic eovf);
        exp_t e;
        int   c0;
        @(negedge clk);
        chk("ready_idle", 64'(bus.Ready_Out), 64'd1);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Carry_In  = cin;
        @(posedge clk);
        #1;
        c0         = cyc;
        e.sum      = esum;
        e.cout     = ecout;
        e.ovf      = eovf;
        e.done_cyc = c0 + 4;
        sb.push_back(e);
        @(negedge clk);
        bus.Start_In  = 1'b0;
        bus.Data_A_In = ~a;
        bus.Data_B_In = {$urandom, $urandom};
        bus.Carry_In  = ~cin;
        chk("enable_run1", 64'(bus.Slice_Enable_Out), 64'd1);
        chk("slice_a_first", 64'(bus.Slice_A_Out), 64'(a[15:0]));
        chk("slice_carry_first", 64'(bus.Slice_Carry_Out), 64'(cin));
        chk("flags_cleared", {62'd0, bus.Carry_Out, bus.Overflow_Out}, 64'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("enable_run", 64'(bus.Slice_Enable_Out), 64'd1);
        end
        @(negedge clk);
        chk("enable_done", 64'(bus.Slice_Enable_Out), 64'd0);
        @(negedge clk);
        chk("ready_after", 64'(bus.Ready_Out), 64'd1);
        chk("sum_held", bus.Sum_Out, esum);
    endtask

    initial begin
        exp_t e;
        int   c0;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        rst           = 1'b1;
        bus.Start_In  = 1'b0;
        bus.Data_A_In = '0;
        bus.Data_B_In = '0;
        bus.Carry_In  = 1'b0;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.Ready_Out), 64'd1);
        chk("rst_enable", 64'(bus.Slice_Enable_Out), 64'd0);
        chk("rst_slices", {31'd0, bus.Slice_Carry_Out, bus.Slice_A_Out, bus.Slice_B_Out}, 64'd0);
        chk("rst_sum", bus.Sum_Out, 64'd0);
        chk("rst_flags", {61'd0, bus.Carry_Out, bus.Overflow_Out, bus.Done_Out}, 64'd0);
        rst = 1'b0;

        // Table-driven full-width adds.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Start pulses during RUN and DONE plus an operand change after accept are all ignored.
        @(negedge clk);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = 64'h0123_4567_89AB_CDEF;
        bus.Data_B_In = 64'h1111_1111_1111_1111;
        bus.Carry_In  = 1'b0;
        @(posedge clk);
        #1;
        c0         = cyc;
        e.sum      = 64'h1234_5678_9ABC_DF00;
        e.cout     = 1'b0;
        e.ovf      = 1'b0;
        e.done_cyc = c0 + 4;
        sb.push_back(e);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.Start_In = (k == 2 || k == 5);
            if (k == 1) bus.Data_A_In = 64'hFFFF_FFFF_FFFF_FFFF;
            if (k == 2) bus.Data_B_In = 64'h5555_5555_5555_5555;
            chk("ign_ready", 64'(bus.Ready_Out), 64'(k == 6));
        end
        repeat (8) @(negedge clk);
        chk("ign_sum_held", bus.Sum_Out, 64'h1234_5678_9ABC_DF00);

        // Reset in the second RUN cycle aborts without a Done.
        @(negedge clk);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = 64'h1111_2222_3333_4444;
        bus.Data_B_In = 64'h1;
        bus.Carry_In  = 1'b0;
        @(posedge clk);
        #1;
        e.sum      = 64'h1111_2222_3333_4445;
        e.cout     = 1'b0;
        e.ovf      = 1'b0;
        e.done_cyc = cyc + 4;
        sb.push_back(e);
        @(negedge clk);
        bus.Start_In = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("abort_ready", 64'(bus.Ready_Out), 64'd1);
        chk("abort_enable", 64'(bus.Slice_Enable_Out), 64'd0);
        chk("abort_sum", bus.Sum_Out, 64'd0);
        chk("abort_flags", {61'd0, bus.Carry_Out, bus.Overflow_Out, bus.Done_Out}, 64'd0);
        chk("abort_slices", {31'd0, bus.Slice_Carry_Out, bus.Slice_A_Out, bus.Slice_B_Out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

        // Start held high: one accept every six cycles, enable only in the four RUN cycles.
        @(negedge clk);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = 64'h1;
        bus.Data_B_In = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.Carry_In  = 1'b0;
        for (int op = 0; op < 3; op++) begin
            @(posedge clk);
            #1;
            e.sum      = 64'h0;
            e.cout     = 1'b1;
            e.ovf      = 1'b0;
            e.done_cyc = cyc + 4;
            sb.push_back(e);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                chk("stream_enable", 64'(bus.Slice_Enable_Out), 64'(k <= 4));
                chk("stream_ready", 64'(bus.Ready_Out), 64'(k == 6));
                if (op == 2 && k == 6) bus.Start_In = 1'b0;
            end
        end

        repeat (10) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
